// File: rtl/ssc_change_dispenser_if.sv
// Change-dispenser handshake bundle: request in, coin stream out, completion.
// master = request/coin consumer side, slave = dispenser.
interface ssc_change_dispenser_if;
  logic       in_valid;
  logic [8:0] in_change;
  logic       in_ready;
  logic       coin_valid;
  logic [6:0] coin_value;
  logic       coin_ready;
  logic       done;
  logic [3:0] coin_cnt;

  modport master (
    output in_valid,
    output in_change,
    input  in_ready,
    input  coin_valid,
    input  coin_value,
    output coin_ready,
    input  done,
    input  coin_cnt
  );

  modport slave (
    input  in_valid,
    input  in_change,
    output in_ready,
    output coin_valid,
    output coin_value,
    input  coin_ready,
    output done,
    output coin_cnt
  );
endinterface

// File: rtl/ssc_change_dispenser.sv
// Greedy change dispenser: accepts an amount, emits one coin per handshake
// (largest denomination not exceeding the remainder), then pulses done with
// the coin count for one cycle.
// Optional feature: define SSC_COIN100_EN to enable the 100 coin (top priority).
module ssc_change_dispenser (
  input  logic                   clk,
  input  logic                   rst_n,
  ssc_change_dispenser_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [8:0] remainder;
  logic [3:0] coin_cnt_q;
  logic [6:0] coin_sel;
  logic       accept;
  logic       coin_xfer;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign coin_xfer = (state == DISP) && bus.coin_ready;

  // Greedy denomination pick from the current remainder; zero outside DISP
  always_comb begin
    coin_sel = '0;
    if (state == DISP) begin
`ifdef SSC_COIN100_EN
      if (remainder >= 9'd100)
        coin_sel = 7'd100;
      else
`endif
      if (remainder >= 9'd50)
        coin_sel = 7'd50;
      else if (remainder >= 9'd10)
        coin_sel = 7'd10;
      else if (remainder >= 9'd5)
        coin_sel = 7'd5;
      else if (remainder != 9'd0)
        coin_sel = 7'd1;
      else
        coin_sel = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_change != 9'd0)
            state_nxt = DISP;
          else
            state_nxt = DONE;
        end
      end
      DISP: begin
        if (bus.coin_ready && (remainder == {2'b00, coin_sel}))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Remainder and coin counter: load/clear on accept, update per coin handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remainder  <= '0;
      coin_cnt_q <= '0;
    end else if (accept) begin
      remainder  <= bus.in_change;
      coin_cnt_q <= '0;
    end else if (coin_xfer) begin
      remainder  <= remainder - {2'b00, coin_sel};
      coin_cnt_q <= coin_cnt_q + 4'd1;
    end
  end

  // Output decode from state
  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.coin_valid = (state == DISP);
    bus.coin_value = coin_sel;
    bus.done       = (state == DONE);
    bus.coin_cnt   = (state == DONE) ? coin_cnt_q : '0;
  end

endmodule

// File: tb/tb_ssc_change_dispenser.sv
// Directed bench for ssc_change_dispenser; expectations follow SSC_COIN100_EN.
module tb_ssc_change_dispenser;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ssc_change_dispenser_if bus ();

  ssc_change_dispenser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_change  = '0;
    bus.coin_ready = 1'b0;
    #2;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.coin_valid !== 1'b0 || bus.coin_value !== 7'd0 ||
        bus.done !== 1'b0 || bus.coin_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b cv=%b val=%0d done=%b cnt=%0d, want 1 0 0 0 0",
               bus.in_ready, bus.coin_valid, bus.coin_value, bus.done, bus.coin_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_greedy_87();
    int exp_c [7];
    exp_c = '{50, 10, 10, 10, 5, 1, 1};
    bus.coin_ready = 1'b1;
    bus.in_change  = 9'd87;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'(exp_c[i]) || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL greedy87_coin%0d: got cv=%b val=%0d done=%b, want cv=1 val=%0d done=0",
                 i, bus.coin_valid, bus.coin_value, bus.done, exp_c[i]);
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.coin_cnt !== 4'd7 || bus.coin_valid !== 1'b0) begin
      n_err++;
      $display("FAIL greedy87_done: got done=%b cnt=%0d cv=%b, want done=1 cnt=7 cv=0",
               bus.done, bus.coin_cnt, bus.coin_valid);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.coin_cnt !== 4'd0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL greedy87_idle: got done=%b cnt=%0d rdy=%b, want 0 0 1",
               bus.done, bus.coin_cnt, bus.in_ready);
    end
  endtask

  task automatic test_zero_change();
    bus.coin_ready = 1'b1;
    bus.in_change  = 9'd0;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.coin_cnt !== 4'd0 || bus.coin_valid !== 1'b0 ||
        bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: got done=%b cnt=%0d cv=%b rdy=%b, want 1 0 0 0",
               bus.done, bus.coin_cnt, bus.coin_valid, bus.in_ready);
    end
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.done !== 1'b0 || bus.coin_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_idle: got rdy=%b done=%b cv=%b, want 1 0 0",
               bus.in_ready, bus.done, bus.coin_valid);
    end
  endtask

  task automatic test_worst_case();
`ifdef SSC_COIN100_EN
    int exp_n = 7;
    int exp_c [12];
    exp_c = '{100, 100, 100, 100, 100, 10, 1, 0, 0, 0, 0, 0};
`else
    int exp_n = 12;
    int exp_c [12];
    exp_c = '{50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 10, 1};
`endif
    bus.coin_ready = 1'b1;
    bus.in_change  = 9'd511;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < exp_n; i++) begin
      n_cmp++;
      if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'(exp_c[i])) begin
        n_err++;
        $display("FAIL worst511_coin%0d: got cv=%b val=%0d, want cv=1 val=%0d",
                 i, bus.coin_valid, bus.coin_value, exp_c[i]);
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.coin_cnt !== 4'(exp_n)) begin
      n_err++;
      $display("FAIL worst511_done: got done=%b cnt=%0d, want done=1 cnt=%0d",
               bus.done, bus.coin_cnt, exp_n);
    end
    tick();
  endtask

  task automatic test_stall_16();
    bus.coin_ready = 1'b0;
    bus.in_change  = 9'd16;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd10) begin
        n_err++;
        $display("FAIL stall16_hold%0d: got cv=%b val=%0d, want cv=1 val=10",
                 i, bus.coin_valid, bus.coin_value);
      end
      if (i < 3) tick();
    end
    bus.coin_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd5) begin
      n_err++;
      $display("FAIL stall16_coin5: got cv=%b val=%0d, want cv=1 val=5", bus.coin_valid, bus.coin_value);
    end
    tick();
    n_cmp++;
    if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd1) begin
      n_err++;
      $display("FAIL stall16_coin1: got cv=%b val=%0d, want cv=1 val=1", bus.coin_valid, bus.coin_value);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.coin_cnt !== 4'd3) begin
      n_err++;
      $display("FAIL stall16_done: got done=%b cnt=%0d, want done=1 cnt=3", bus.done, bus.coin_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int saw_done;
    bus.coin_ready = 1'b1;
    bus.in_change  = 9'd60;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd50) begin
      n_err++;
      $display("FAIL rstmid_coin50: got cv=%b val=%0d, want cv=1 val=50", bus.coin_valid, bus.coin_value);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.coin_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.coin_value !== 7'd0 ||
        bus.done !== 1'b0 || bus.coin_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL rstmid_async: got cv=%b rdy=%b val=%0d done=%b cnt=%0d, want 0 1 0 0 0",
               bus.coin_valid, bus.in_ready, bus.coin_value, bus.done, bus.coin_cnt);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.coin_valid !== 1'b0) saw_done++;
    end
    n_cmp++;
    if (saw_done != 0) begin
      n_err++;
      $display("FAIL rstmid_no_done: got %0d cycles with done/coin_valid, want 0", saw_done);
    end
    bus.in_change = 9'd5;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd5) begin
      n_err++;
      $display("FAIL rstmid_req5_coin: got cv=%b val=%0d, want cv=1 val=5", bus.coin_valid, bus.coin_value);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.coin_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL rstmid_req5_done: got done=%b cnt=%0d, want done=1 cnt=1", bus.done, bus.coin_cnt);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    int exp_c [3];
    int waited;
    exp_c = '{5, 1, 1};
    bus.coin_ready = 1'b1;
    bus.in_change  = 9'd7;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_change = 9'd30;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'(exp_c[i]) || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_coin%0d: got cv=%b val=%0d rdy=%b, want cv=1 val=%0d rdy=0",
                 i, bus.coin_valid, bus.coin_value, bus.in_ready, exp_c[i]);
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.coin_cnt !== 4'd3 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL busy_first_done: got done=%b cnt=%0d rdy=%b, want 1 3 0",
               bus.done, bus.coin_cnt, bus.in_ready);
    end
    waited = 0;
    do begin
      tick();
      waited++;
    end while (bus.in_ready !== 1'b1 && waited < 10);
    n_cmp++;
    if (waited != 1 || bus.coin_valid !== 1'b0) begin
      n_err++;
      $display("FAIL busy_ready_wait: got %0d cycles cv=%b, want 1 cycle cv=0", waited, bus.coin_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd10) begin
        n_err++;
        $display("FAIL busy_second_coin%0d: got cv=%b val=%0d, want cv=1 val=10",
                 i, bus.coin_valid, bus.coin_value);
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.coin_cnt !== 4'd3) begin
      n_err++;
      $display("FAIL busy_second_done: got done=%b cnt=%0d, want done=1 cnt=3", bus.done, bus.coin_cnt);
    end
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.coin_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_single_accept: got rdy=%b cv=%b done=%b, want 1 0 0",
               bus.in_ready, bus.coin_valid, bus.done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_greedy_87();
    test_zero_change();
    test_worst_case();
    test_stall_16();
    test_reset_mid();
    test_ignore_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
